// File: rtl/time_of_day_pkg.sv
// Shared encodings, field limits and display helpers for the time-of-day counter.
package time_of_day_pkg;

  typedef enum logic [1:0] {
    SET_SEC = 2'b00,
    SET_MIN = 2'b01,
    SET_HR  = 2'b10,
    RUN     = 2'b11
  } order_e;

  localparam logic [7:0] SEC_MAX = 8'd59;
  localparam logic [7:0] MIN_MAX = 8'd59;
  localparam logic [7:0] HR_MAX  = 8'd23;
  localparam logic [7:0] HR_NOON = 8'd12;

  // Binary 0..99 to packed BCD, tens in [7:4].
  function automatic logic [7:0] to_bcd8(input logic [7:0] bin);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(bin / 8'd10);
    units = 4'(bin % 8'd10);
    return {tens, units};
  endfunction

  function automatic logic [7:0] hr_to_12(input logic [7:0] hr24);
    logic [7:0] hr12;
    if (hr24 == 8'd0)
      hr12 = HR_NOON;
    else if (hr24 > HR_NOON)
      hr12 = hr24 - HR_NOON;
    else
      hr12 = hr24;
    return hr12;
  endfunction

  function automatic logic [7:0] inc_mod(input logic [7:0] v, input logic [7:0] max);
    return (v == max) ? 8'd0 : v + 8'd1;
  endfunction

endpackage

// File: rtl/time_of_day_counter_tick_gen.sv
// Prescaler dividing CLK down to a one-cycle wrap strobe once per CLOCK_FREQ cycles.
module tick_gen #(
  parameter int CLOCK_FREQ = 50_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic hold,
  output logic wrap
);

  localparam int CW = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLOCK_FREQ - 1);

  logic [CW-1:0] count;

  // Hold forces the count to zero so a later release starts a full period.
  assign wrap = !hold && (count == LAST);

  always_ff @(posedge CLK) begin
    if (RST || hold)
      count <= '0;
    else if (wrap)
      count <= '0;
    else
      count <= count + CW'(1);
  end

endmodule

// File: rtl/time_of_day_counter.sv
// Time-of-day counter: hh:mm:ss with run/set modes, 12/24 h display and optional BCD outputs.
module time_of_day_counter
  import time_of_day_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter bit OUT_BCD    = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       INCREMENT,
  input  logic [1:0] ORDER,
  input  logic       HOUR_12,
  output logic [7:0] seconds,
  output logic [7:0] minutes,
  output logic [7:0] hours,
  output logic       PM,
  output logic       SEC_TICK,
  output logic       DAY_TICK
);

  order_e     order;
  logic       run;
  logic       sec_wrap;
  logic       step;
  logic       inc_q;
  logic [7:0] sec_r;
  logic [7:0] min_r;
  logic [7:0] hr_r;
  logic       sec_last;
  logic       min_last;
  logic       hr_last;
  logic [7:0] hr_disp;

  assign order = order_e'(ORDER);
  assign run   = (order == RUN);
  assign step  = INCREMENT && !inc_q;

  assign sec_last = (sec_r == SEC_MAX);
  assign min_last = (min_r == MIN_MAX);
  assign hr_last  = (hr_r == HR_MAX);

  tick_gen #(
    .CLOCK_FREQ(CLOCK_FREQ)
  ) u_tick_gen (
    .CLK (CLK),
    .RST (RST),
    .hold(!run),
    .wrap(sec_wrap)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      inc_q    <= 1'b0;
      sec_r    <= 8'd0;
      min_r    <= 8'd0;
      hr_r     <= 8'd0;
      SEC_TICK <= 1'b0;
      DAY_TICK <= 1'b0;
    end else begin
      inc_q    <= INCREMENT;
      SEC_TICK <= sec_wrap;
      DAY_TICK <= sec_wrap && sec_last && min_last && hr_last;
      // sec_wrap only fires in run mode, so steps and carries never collide.
      if (sec_wrap) begin
        sec_r <= inc_mod(sec_r, SEC_MAX);
        if (sec_last) begin
          min_r <= inc_mod(min_r, MIN_MAX);
          if (min_last)
            hr_r <= inc_mod(hr_r, HR_MAX);
        end
      end else if (step) begin
        case (order)
          SET_SEC: sec_r <= inc_mod(sec_r, SEC_MAX);
          SET_MIN: min_r <= inc_mod(min_r, MIN_MAX);
          SET_HR:  hr_r  <= inc_mod(hr_r, HR_MAX);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    hr_disp = hr_r;
    if (HOUR_12)
      hr_disp = hr_to_12(hr_r);
  end

  assign PM = (hr_r >= HR_NOON);

  generate
    if (OUT_BCD) begin : g_bcd
      assign seconds = to_bcd8(sec_r);
      assign minutes = to_bcd8(min_r);
      assign hours   = to_bcd8(hr_disp);
    end else begin : g_bin
      assign seconds = sec_r;
      assign minutes = min_r;
      assign hours   = hr_disp;
    end
  endgenerate

endmodule

// File: tb/tb_time_of_day_counter.sv
// Scoreboard bench: a seconds-of-day reference model predicts ticks and field values for binary and BCD instances.
module tb_time_of_day_counter;

  localparam int CF = 4;
  localparam int DAY_SECS = 86400;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       INCREMENT = 1'b0;
  logic [1:0] ORDER = 2'b11;
  logic       HOUR_12 = 1'b0;

  logic [7:0] sec_b, min_b, hr_b, sec_d, min_d, hr_d;
  logic       pm_b, pm_d, st_b, st_d, dt_b, dt_d;

  always #5 CLK = ~CLK;

  time_of_day_counter #(.CLOCK_FREQ(CF), .OUT_BCD(1'b0)) dut_bin (
    .CLK(CLK), .RST(RST), .INCREMENT(INCREMENT), .ORDER(ORDER), .HOUR_12(HOUR_12),
    .seconds(sec_b), .minutes(min_b), .hours(hr_b), .PM(pm_b),
    .SEC_TICK(st_b), .DAY_TICK(dt_b)
  );

  time_of_day_counter #(.CLOCK_FREQ(CF), .OUT_BCD(1'b1)) dut_bcd (
    .CLK(CLK), .RST(RST), .INCREMENT(INCREMENT), .ORDER(ORDER), .HOUR_12(HOUR_12),
    .seconds(sec_d), .minutes(min_d), .hours(hr_d), .PM(pm_d),
    .SEC_TICK(st_d), .DAY_TICK(dt_d)
  );

  typedef struct {
    int cyc;
    int tod;
    bit day;
  } tick_t;

  tick_t exp_q[$];
  int    tod = 0;
  int    run_cnt = 0;
  int    cyc = 0;
  bit    prev_inc = 1'b0;
  int    m_h, m_m, m_s;
  int    n_pass = 0;
  int    n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  function automatic int fld(input int t, input int o);
    if (o == 0) return t % 60;
    if (o == 1) return (t / 60) % 60;
    return t / 3600;
  endfunction

  function automatic int to_bcd(input int v);
    return (v / 10) * 16 + v % 10;
  endfunction

  // Expected {seconds, minutes, hours, PM} for a given seconds-of-day value.
  function automatic int pack(input int t, input bit h12, input bit as_bcd);
    int s, m, h, pm;
    s  = t % 60;
    m  = (t / 60) % 60;
    h  = t / 3600;
    pm = (t >= 12 * 3600) ? 1 : 0;
    if (h12) h = (h % 12 == 0) ? 12 : h % 12;
    if (as_bcd) begin
      s = to_bcd(s);
      m = to_bcd(m);
      h = to_bcd(h);
    end
    return (s << 17) | (m << 9) | (h << 1) | pm;
  endfunction

  // Reference model: time as seconds-of-day, run time as cycles since entering run.
  always @(posedge CLK) begin
    cyc++;
    if (RST) begin
      tod      = 0;
      run_cnt  = 0;
      prev_inc = 1'b0;
    end else begin
      if (ORDER == 2'b11) begin
        run_cnt++;
        if (run_cnt == CF) begin
          run_cnt = 0;
          tod = (tod + 1) % DAY_SECS;
          exp_q.push_back('{cyc: cyc, tod: tod, day: (tod == 0)});
        end
      end else begin
        run_cnt = 0;
        if (INCREMENT && !prev_inc) begin
          m_s = tod % 60;
          m_m = (tod / 60) % 60;
          m_h = tod / 3600;
          case (ORDER)
            2'b00:   m_s = (m_s + 1) % 60;
            2'b01:   m_m = (m_m + 1) % 60;
            default: m_h = (m_h + 1) % 24;
          endcase
          tod = m_h * 3600 + m_m * 60 + m_s;
        end
      end
      prev_inc = INCREMENT;
    end
  end

  // Monitor: SEC_TICK is the output-valid; pop and compare the predicted second.
  always @(negedge CLK) begin
    tick_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      chk("tick_present", 0, 1);
      void'(exp_q.pop_front());
    end
    if (st_b === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("tick_spurious", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("tick_cycle", cyc, e.cyc);
        chk("tick_time_bin", int'({sec_b, min_b, hr_b, pm_b}), pack(e.tod, HOUR_12, 1'b0));
        chk("tick_time_bcd", int'({sec_d, min_d, hr_d, pm_d}), pack(e.tod, HOUR_12, 1'b1));
        chk("day_tick", int'(dt_b), int'(e.day));
        chk("day_tick_bcd", int'(dt_d), int'(e.day));
        chk("sec_tick_bcd", int'(st_d), 1);
      end
    end else if (dt_b === 1'b1) begin
      chk("day_tick_without_sec_tick", 1, 0);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check_state(input string name);
    chk({name, "_bin"}, int'({sec_b, min_b, hr_b, pm_b}), pack(tod, HOUR_12, 1'b0));
    chk({name, "_bcd"}, int'({sec_d, min_d, hr_d, pm_d}), pack(tod, HOUR_12, 1'b1));
  endtask

  task automatic press(input logic [1:0] o);
    ORDER = o;
    INCREMENT = 1'b1;
    cycles(1);
    INCREMENT = 1'b0;
    cycles(1);
  endtask

  task automatic set_field(input int o, input int target, input bit check_each);
    int guard = 0;
    while (fld(tod, o) != target && guard < 100) begin
      press(2'(o));
      if (check_each) check_state("set_step");
      guard++;
    end
    chk("set_field_reached", fld(tod, o), target);
  endtask

  task automatic wait_phase(input int phase);
    int guard = 0;
    while (run_cnt != phase && guard < 4 * CF) begin
      cycles(1);
      guard++;
    end
    chk("phase_reached", run_cnt, phase);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values in both display modes
    cycles(2);
    check_state("reset");
    chk("reset_sec_tick", int'(st_b), 0);
    chk("reset_day_tick", int'(dt_b), 0);
    HOUR_12 = 1'b1;
    #1;
    check_state("reset_h12");
    chk("reset_hours_bcd_h12", int'(hr_d), 8'h12);
    HOUR_12 = 1'b0;
    RST = 1'b0;

    // 16 run cycles: ticks on edges 4, 8, 12, 16
    cycles(16);
    check_state("run16");
    chk("seconds_after_16", int'(sec_b), 4);

    // Preload 23:59:58, stepping hours in 12 h mode with display checks at every step
    RST = 1'b1;
    cycles(1);
    RST = 1'b0;
    ORDER = 2'b10;
    HOUR_12 = 1'b1;
    cycles(1);
    check_state("hour0_h12");
    set_field(2, 23, 1'b1);
    HOUR_12 = 1'b0;
    #1;
    chk("hours_bcd_23", int'(hr_d), 8'h23);
    set_field(1, 59, 1'b0);
    set_field(0, 58, 1'b0);
    check_state("preload");
    ORDER = 2'b11;
    cycles(2 * CF + 1);
    check_state("after_rollover");

    // Held INCREMENT gives one minute step, no carry into hours
    set_field(2, 5, 1'b0);
    set_field(1, 59, 1'b0);
    ORDER = 2'b01;
    INCREMENT = 1'b1;
    cycles(10);
    INCREMENT = 1'b0;
    cycles(1);
    check_state("held_step");
    chk("held_step_minutes", int'(min_b), 0);
    chk("held_step_hours", int'(hr_b), 5);

    // Reset coincident with a tick edge at 12:34:56
    set_field(2, 12, 1'b0);
    set_field(1, 34, 1'b0);
    set_field(0, 56, 1'b0);
    ORDER = 2'b11;
    wait_phase(CF - 1);
    RST = 1'b1;
    cycles(1);
    RST = 1'b0;
    check_state("reset_on_tick");
    chk("sec_tick_after_reset", int'(st_b), 0);
    cycles(CF + 1);

    // Leave run mid-second and return: full period before next tick
    wait_phase(2);
    ORDER = 2'b00;
    cycles(3);
    ORDER = 2'b11;
    cycles(2 * CF + 1);
    check_state("resume");

    // Randomised mode/step/display traffic
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) == 0) ORDER = 2'b11;
      else ORDER = 2'($urandom_range(0, 3));
      INCREMENT = 1'($urandom_range(0, 1));
      HOUR_12 = 1'($urandom_range(0, 1));
      RST = ($urandom_range(0, 29) == 0);
      cycles($urandom_range(1, 6));
      check_state("random");
      RST = 1'b0;
    end

    INCREMENT = 1'b0;
    ORDER = 2'b11;
    cycles(CF + 2);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/time_of_day_counter.md
# time_of_day_counter

Parametrised time-of-day counter. It divides the system clock into a 1 s tick and keeps seconds, minutes and hours with correct 60/60/24 carries. It adds a set mode in which one field at a time is stepped by an edge-detected button, a 12/24-hour display mode, optional packed-BCD outputs, and tick/rollover strobes. It feeds the display and alarm logic in the same clock domain.

## Interface
- CLOCK_FREQ, 50_000_000: CLK cycles per second (≥2); benches use 4.
- OUT_BCD, 0: 0 = binary field outputs; 1 = packed BCD (tens in [7:4], units in [3:0]).
- CLK  in  1  system clock, all logic on posedge.
- RST  in  1  reset. One clock; reset is synchronous and active-high.
- INCREMENT  in  1  set-mode step button, level, already synchronised upstream.
- ORDER  in  2  mode/field select: 00 set seconds, 01 set minutes, 10 set hours, 11 run.
- HOUR_12  in  1  1 = 12-hour display, 0 = 24-hour display.
- seconds  out  8  seconds field, 0..59.
- minutes  out  8  minutes field, 0..59.
- hours  out  8  hours field: 0..23 in 24 h mode; 1..12 in 12 h mode.
- PM  out  1  1 when internal hour ≥ 12, in either display mode.
- SEC_TICK  out  1  one-cycle strobe on each run-mode second advance.
- DAY_TICK  out  1  one-cycle strobe on the 23:59:59 → 00:00:00 rollover.

## Operation
- Internal state: prescaler (0..CLOCK_FREQ-1, $clog2(CLOCK_FREQ) bits), sec_r, min_r, hr_r (binary, hr_r 0..23), inc_q (previous INCREMENT).
- Run (ORDER=11): prescaler increments each cycle. When prescaler = CLOCK_FREQ-1 it returns to 0 and the time advances one second:
  - sec_r 59 → 0 carries into min_r;
  - min_r 59 → 0 carries into hr_r;
  - hr_r 23 → 0 with all three carries asserts DAY_TICK.
  - All carries resolve on the same edge; no field ever holds an out-of-range value, even for one cycle.
- Set (ORDER≠11): prescaler is held at 0; no SEC_TICK or DAY_TICK.
  - Step event = INCREMENT=1 and inc_q=0. It increments only the selected field, modulo 60 or 24, with no carry into other fields. INCREMENT held high produces exactly one step.
  - ORDER=00 additionally clears the prescaler, so seconds restart cleanly on return to run.
- Run → set or set → run: the prescaler is 0 on entry to run, so the first SEC_TICK comes exactly CLOCK_FREQ cycles after the first run cycle.
- ORDER change in the same cycle as a step event: the step applies to the field selected by the new ORDER value sampled on that edge.
- Display mapping is combinational from registers only, with no input-to-output path except HOUR_12:
  - 12 h mode: hr_r 0 → 12, 1..12 → same, 13..23 → hr_r-12.
  - PM = (hr_r ≥ 12).
  - OUT_BCD=1 converts each field to two BCD digits after the 12 h mapping.

## Timing
- RST sampled high at an edge: prescaler=0, sec_r=min_r=hr_r=0, inc_q=0, SEC_TICK=0, DAY_TICK=0, PM=0.
  - Resulting outputs: seconds=0, minutes=0; hours=0 in 24 h mode, or 12 (0x0C binary, 0x12 BCD) in 12 h mode.
- RST has priority over every other event, including a coincident tick or step. Reset mid-second discards the partial count.
- After RST deasserts in run mode, the first advance occurs on the CLOCK_FREQ-th rising edge.
- SEC_TICK and DAY_TICK are registered. Each is high for exactly the one cycle in which the new time is first visible.
- Step latency: the field updates on the same edge that samples the step event.
- HOUR_12 toggling changes hours and PM combinationally and never alters hr_r.

## Structure
- Package time_of_day_pkg holds:
  - ORDER encodings as an enum (SET_SEC, SET_MIN, SET_HR, RUN);
  - field limits SEC_MAX=59, MIN_MAX=59, HR_MAX=23;
  - function to_bcd8 (binary 0..99 → packed BCD);
  - function hr_to_12 (24 h hour → 12 h hour).
- One sub-module, tick_gen: parametrised prescaler with a hold/clear input and a one-cycle wrap strobe. The top level owns the time fields, step edge detect and display mapping.

## Test plan
- CLOCK_FREQ=4, run from reset for 16 cycles → SEC_TICK high on edges 4, 8, 12, 16; seconds reads 1, 2, 3, 4; DAY_TICK never high.
- Preload 23:59:58 via set mode, then run 2 s → 23:59:59, then 00:00:00; DAY_TICK high for exactly one cycle, coincident with the second SEC_TICK; PM falls 1 → 0.
- ORDER=01 with minutes=59, one INCREMENT pulse held high 10 cycles → minutes=0, hours unchanged; exactly one step; no SEC_TICK during set.
- HOUR_12=1, step hours through 0, 12, 13, 23 → hours displays 12, 12, 1, 11 and PM reads 0, 1, 1, 1; with OUT_BCD=1, hr_r=23 in 24 h mode gives hours=0x23.
- Run at 12:34:56, assert RST for one cycle coincident with a SEC_TICK edge → 00:00:00, SEC_TICK=0 in the next cycle; next tick comes CLOCK_FREQ cycles after RST falls.
- Switch ORDER 11 → 00 mid-second, back to 11 → prescaler restarts; first SEC_TICK exactly CLOCK_FREQ cycles after re-entering run.
